sync_mark_generator: RTL
========================

Name: sync_mark_generator

Overview:
Write-path counterpart of the encoding auto-detector. On a start pulse it emits, MSB-first, the raw encoded cell stream of the preamble and sync/address-mark sequence for the selected encoding. The stream is sized so that the read-side sync detector for that encoding fires. The block sits between the write controller and the write serializer. Handoff uses a valid/ready bit handshake.

Parameters:
MFM_PRE_WORDS, 12, preamble word count for MFM and M2FM (0x00 bytes, 8'd1..255)
FM_PRE_WORDS, 6, preamble word count for FM and Tandy
CBM_PRE_WORDS, 5, preamble word count for GCR-CBM (0xFFFF words, 80 one-cells)
APPLE_PRE_WORDS, 5, number of 10-bit self-sync words for GCR-AP6 and GCR-AP5

Ports:
clk  in  1  system clock
reset_n  in  1  synchronous active-low reset
enable  in  1  block enable; deassert aborts any sequence
start  in  1  one-cycle request; sampled only in IDLE
encoding  in  3  ENC_* code, latched at start (000 MFM, 001 FM, 010 CBM, 011 AP6, 100 AP5, 101 M2FM, 110 Tandy)
bit_out  out  1  current raw cell
bit_valid  out  1  bit_out holds a cell
bit_ready  in  1  serializer accepts the cell when bit_valid && bit_ready
busy  out  1  sequence in progress
done  out  1  one-cycle pulse after the last cell transfers
error  out  1  one-cycle pulse when start is given with encoding 3'b111

Behaviour:
- Interface: single clock; synchronous active-low reset (reset_n).
- Reset values: bit_out=0, bit_valid=0, busy=0, done=0, error=0. FSM=IDLE, counters=0.
- FSM states: IDLE, PRE, SYNC, FIN.
  - IDLE: start && enable && encoding!=111 -> latch encoding, load the first preamble word -> PRE. busy=1 and bit_valid=1 on the next cycle (latency 1).
  - IDLE: start with encoding==111 -> error=1 for 1 cycle; stay in IDLE; no cells emitted.
  - PRE: emit preamble words. After the last preamble cell transfers: go to SYNC, or to FIN if sync count is 0.
  - SYNC: emit sync words. After the last sync cell transfers -> FIN.
  - FIN: busy=0, bit_valid=0, done=1 for one cycle -> IDLE.
- Per-encoding tables (raw cells, MSB first):
  - MFM: pre 0xAAAA x MFM_PRE_WORDS; sync 0x4489 x3
  - FM: pre 0xAAAA x FM_PRE_WORDS; sync 0xF57E x1 (FE/C7)
  - M2FM: pre 0xAAAA x MFM_PRE_WORDS; sync 0xF77A x1
  - Tandy: pre 0xAAAA x FM_PRE_WORDS; sync 0xF56A x1 (F8/C7)
  - CBM: pre 0xFFFF x CBM_PRE_WORDS; no sync words
  - AP6: pre 10-bit 0x3FC x APPLE_PRE_WORDS; sync 8-bit D5, AA, 96
  - AP5: same as AP6 but sync D5, AA, B5
- Word length is 16, 10 or 8 cells. The bit index counts down from length-1 to 0. The word counter is 8 bits.
- Handshake:
  - The cell advances only on bit_valid && bit_ready.
  - bit_out is held stable while bit_valid && !bit_ready.
  - bit_valid stays high continuously between words; there are no bubbles.
- Boundaries:
  - start while busy: ignored.
  - encoding changes mid-sequence: ignored (the latched value is used).
  - enable=0 in any state: the next cycle gives IDLE with bit_valid=0 and busy=0; no done pulse.
  - reset_n=0 mid-sequence: all outputs return to reset values on the next edge.
  - start in the same cycle as done: ignored; start is accepted from the following cycle.
  - bit_ready held low indefinitely: the block stalls without loss.

Optional Feature:
SYNC_GEN_CRC_INIT_EN
- Defined:
  - Adds outputs crc_init[15:0] and crc_init_valid. crc_init_valid pulses together with done.
  - crc_init values: 0xCDB4 for MFM (CCITT CRC after A1 A1 A1); 0xFFFF for FM, Tandy and M2FM; 0x0000 for CBM, AP6 and AP5.
  - crc_init holds its value until the next start; reset value 0x0000.
- Undefined: the ports and logic are absent; behaviour is otherwise identical.

Test Plan:
- MFM, bit_ready=1: start with encoding=000 -> 192 cells of 1010… then 0x4489 x3 (48 cells). Total 240 cells, done on the cycle after the last cell, busy low with done.
- FM, bit_ready toggling 1/0 each cycle: start with encoding=001 -> 96 cells of 0xAAAA then 0xF57E. Total 112 transfers; bit_out stable during stalls; done exactly once.
- AP5: start with encoding=100 -> 5 x 1111111100 then D5 AA B5. 74 cells total.
- CBM: start with encoding=010 -> 80 consecutive 1 cells, no sync words, then done.
- Abort and illegal code: start MFM, drop enable at cell 50 -> bit_valid=0 and busy=0 next cycle, no done. Then start with encoding=111 -> error pulse, bit_valid stays 0.
- With SYNC_GEN_CRC_INIT_EN defined: after the MFM sequence, crc_init=0xCDB4 with crc_init_valid coincident with done; after a Tandy sequence, crc_init=0xFFFF.

Source files
------------

// File: rtl/sync_mark_generator.sv
// Emits the raw preamble + sync/address-mark cell stream for the selected encoding, MSB first.
// Optional SYNC_GEN_CRC_INIT_EN adds crc_init/crc_init_valid for the following CRC engine.
module sync_mark_generator #(
  parameter int MFM_PRE_WORDS   = 12,
  parameter int FM_PRE_WORDS    = 6,
  parameter int CBM_PRE_WORDS   = 5,
  parameter int APPLE_PRE_WORDS = 5
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  input  logic        start,
  input  logic [2:0]  encoding,
  output logic        bit_out,
  output logic        bit_valid,
  input  logic        bit_ready,
  output logic        busy,
  output logic        done,
  output logic        error
`ifdef SYNC_GEN_CRC_INIT_EN
  ,
  output logic [15:0] crc_init,
  output logic        crc_init_valid
`endif
);

  // state   | meaning
  // IDLE    | waiting for start
  // PRE     | emitting preamble words
  // SYNC    | emitting sync / address-mark words
  // FIN     | one-cycle done pulse, back to IDLE
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PRE  = 2'd1,
    ST_SYNC = 2'd2,
    ST_FIN  = 2'd3
  } state_t;

  localparam logic [2:0] ENC_MFM     = 3'b000;
  localparam logic [2:0] ENC_FM      = 3'b001;
  localparam logic [2:0] ENC_CBM     = 3'b010;
  localparam logic [2:0] ENC_AP6     = 3'b011;
  localparam logic [2:0] ENC_AP5     = 3'b100;
  localparam logic [2:0] ENC_M2FM    = 3'b101;
  localparam logic [2:0] ENC_TANDY   = 3'b110;
  localparam logic [2:0] ENC_ILLEGAL = 3'b111;

  function automatic logic [15:0] pre_word(input logic [2:0] enc);
    logic [15:0] w;
    case (enc)
      ENC_CBM:          w = 16'hFFFF;
      ENC_AP6, ENC_AP5: w = 16'h03FC;
      default:          w = 16'hAAAA;
    endcase
    return w;
  endfunction

  function automatic logic [3:0] pre_top(input logic [2:0] enc);
    logic [3:0] t;
    case (enc)
      ENC_AP6, ENC_AP5: t = 4'd9;
      default:          t = 4'd15;
    endcase
    return t;
  endfunction

  function automatic logic [7:0] pre_count(input logic [2:0] enc);
    logic [7:0] n;
    case (enc)
      ENC_MFM, ENC_M2FM: n = 8'(MFM_PRE_WORDS);
      ENC_FM, ENC_TANDY: n = 8'(FM_PRE_WORDS);
      ENC_CBM:           n = 8'(CBM_PRE_WORDS);
      ENC_AP6, ENC_AP5:  n = 8'(APPLE_PRE_WORDS);
      default:           n = 8'd0;
    endcase
    return n;
  endfunction

  function automatic logic [7:0] sync_count(input logic [2:0] enc);
    logic [7:0] n;
    case (enc)
      ENC_MFM, ENC_AP6, ENC_AP5:     n = 8'd3;
      ENC_FM, ENC_M2FM, ENC_TANDY:   n = 8'd1;
      default:                       n = 8'd0;
    endcase
    return n;
  endfunction

  function automatic logic [3:0] sync_top(input logic [2:0] enc);
    logic [3:0] t;
    case (enc)
      ENC_AP6, ENC_AP5: t = 4'd7;
      default:          t = 4'd15;
    endcase
    return t;
  endfunction

  // words_left counts down, so 3/2/1 selects the first/second/third Apple mark byte
  function automatic logic [15:0] sync_word(input logic [2:0] enc, input logic [7:0] words_left);
    logic [15:0] w;
    case (enc)
      ENC_MFM:   w = 16'h4489;
      ENC_FM:    w = 16'hF57E;
      ENC_M2FM:  w = 16'hF77A;
      ENC_TANDY: w = 16'hF56A;
      ENC_AP6, ENC_AP5: begin
        case (words_left)
          8'd3:    w = 16'h00D5;
          8'd2:    w = 16'h00AA;
          default: w = (enc == ENC_AP6) ? 16'h0096 : 16'h00B5;
        endcase
      end
      default:   w = 16'h0000;
    endcase
    return w;
  endfunction

  function automatic logic [15:0] crc_seed(input logic [2:0] enc);
    logic [15:0] c;
    case (enc)
      ENC_MFM:                     c = 16'hCDB4;
      ENC_FM, ENC_M2FM, ENC_TANDY: c = 16'hFFFF;
      default:                     c = 16'h0000;
    endcase
    return c;
  endfunction

  state_t      state_q, state_d;
  logic [2:0]  enc_q, enc_d;
  logic [3:0]  bit_idx_q, bit_idx_d;
  logic [7:0]  word_cnt_q, word_cnt_d;
  logic        error_q, error_d;
  logic [15:0] crc_q, crc_d;
  logic [15:0] cur_word;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      enc_q      <= 3'd0;
      bit_idx_q  <= 4'd0;
      word_cnt_q <= 8'd0;
      error_q    <= 1'b0;
      crc_q      <= 16'h0000;
    end else begin
      state_q    <= state_d;
      enc_q      <= enc_d;
      bit_idx_q  <= bit_idx_d;
      word_cnt_q <= word_cnt_d;
      error_q    <= error_d;
      crc_q      <= crc_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    enc_d      = enc_q;
    bit_idx_d  = bit_idx_q;
    word_cnt_d = word_cnt_q;
    error_d    = 1'b0;
    crc_d      = crc_q;

    if (!enable) begin
      state_d    = ST_IDLE;
      bit_idx_d  = 4'd0;
      word_cnt_d = 8'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            if (encoding == ENC_ILLEGAL) begin
              error_d = 1'b1;
            end else begin
              enc_d      = encoding;
              word_cnt_d = pre_count(encoding);
              bit_idx_d  = pre_top(encoding);
              crc_d      = crc_seed(encoding);
              state_d    = ST_PRE;
            end
          end
        end
        ST_PRE, ST_SYNC: begin
          if (bit_ready) begin
            if (bit_idx_q != 4'd0) begin
              bit_idx_d = bit_idx_q - 4'd1;
            end else if (word_cnt_q > 8'd1) begin
              word_cnt_d = word_cnt_q - 8'd1;
              bit_idx_d  = (state_q == ST_PRE) ? pre_top(enc_q) : sync_top(enc_q);
            end else if (state_q == ST_PRE && sync_count(enc_q) != 8'd0) begin
              word_cnt_d = sync_count(enc_q);
              bit_idx_d  = sync_top(enc_q);
              state_d    = ST_SYNC;
            end else begin
              word_cnt_d = 8'd0;
              bit_idx_d  = 4'd0;
              state_d    = ST_FIN;
            end
          end
        end
        ST_FIN: begin
          state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    cur_word = 16'h0000;
    if (state_q == ST_PRE) begin
      cur_word = pre_word(enc_q);
    end else if (state_q == ST_SYNC) begin
      cur_word = sync_word(enc_q, word_cnt_q);
    end
  end

  assign bit_valid = (state_q == ST_PRE) || (state_q == ST_SYNC);
  assign busy      = bit_valid;
  assign bit_out   = bit_valid & cur_word[bit_idx_q];
  assign done      = (state_q == ST_FIN);
  assign error     = error_q;

`ifdef SYNC_GEN_CRC_INIT_EN
  assign crc_init       = crc_q;
  assign crc_init_valid = done;
`else
  // Seed is still tracked so the default build shares one datapath; it simply has no sink.
  logic crc_unused;
  assign crc_unused = ^crc_q;
`endif

endmodule
